// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit:
// FSM encoding, XLEN, PC step and the buffered {pc, instr} entry.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer of DEPTH {pc, instr} entries with flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full buffer is legal only when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests into a buffer.
// Define FETCH_PERF_CNT_EN to add the stall_cnt performance counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [AW:0]     count;
    logic [AW+1:0]   in_flight;
    logic            full;
    logic            empty;
    logic            grant;
    logic            resp;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    // Reserve a buffer slot for the outstanding response before asking again.
    assign in_flight = {1'b0, count} + {{(AW+1){1'b0}}, state == ST_WAIT};
    assign imem_req  = !rst && (state != ST_DROP) && !full
                     && (in_flight < (AW+2)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;
    assign resp      = (state == ST_WAIT) && imem_rvalid;

    assign push_entry.pc    = req_pc;
    assign push_entry.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (resp && !redirect),
        .pop  (out_valid && out_ready),
        .flush(redirect),
        .din  (push_entry),
        .dout (head),
        .count(count),
        .full (full),
        .empty(empty)
    );

    assign out_valid = !empty && !rst;
    assign out_instr = out_valid ? head.instr : '0;
    assign out_pc    = out_valid ? head.pc    : '0;

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            // A response still owed by memory must be swallowed in DROP.
            if (grant || (state != ST_IDLE && !imem_rvalid))
                state_nxt = ST_DROP;
            else
                state_nxt = ST_IDLE;
        end else begin
            unique case (1'b1)
                state == ST_IDLE: if (grant) state_nxt = ST_WAIT;
                state == ST_WAIT: if (imem_rvalid)
                                      state_nxt = grant ? ST_WAIT : ST_IDLE;
                state == ST_DROP: if (imem_rvalid) state_nxt = ST_IDLE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect)
                fetch_pc <= align_pc(redirect_pc);
            else if (grant)
                fetch_pc <= fetch_pc + PC_INC;
            if (grant) req_pc <= fetch_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_ready && !out_valid && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a one-outstanding memory model
// whose response latency is adjustable per phase.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH(2),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory: grants only when idle or retiring, answers after lat cycles.
    logic        gnt_en = 1'b0;
    int          lat = 1;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_wait = 0;

    assign imem_rvalid = pend && (pend_wait == 0);
    assign imem_gnt    = gnt_en && (!pend || imem_rvalid);
    assign imem_rdata  = imem_rvalid ? instr_of(pend_addr) : 32'h0;

    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            pend      <= 1'b1;
            pend_addr <= imem_addr;
            pend_wait <= lat - 1;
        end else if (imem_rvalid) begin
            pend <= 1'b0;
        end else if (pend && pend_wait > 0) begin
            pend_wait <= pend_wait - 1;
        end
    end

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic mon_en = 1'b1;
    logic rdy_en = 1'b0;
    logic rdy_force = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic void expect_pc(input logic [31:0] p);
        exp_t e;
        e.pc    = p;
        e.instr = instr_of(p);
        sb.push_back(e);
    endfunction

    always begin
        @(posedge clk);
        #2;
        out_ready = rdy_force || (rdy_en && sb.size() != 0);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got pc %h instr %h",
                         out_pc, out_instr);
            end else begin
                e = sb.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_instr", out_instr, e.instr);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick(1);
        redirect    = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got %0d undelivered expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_grant(input string name);
        int k = 0;
        @(negedge clk);
        while (!(imem_req && imem_gnt) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!(imem_req && imem_gnt)) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got no grant expected grant", name);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  k;
        logic hit;

        gnt_en = 1'b1;
        lat    = 1;
        tick(3);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);

        // Back-to-back fetch from RESET_PC with memory always ready.
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        rdy_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("p1_first_req", {31'b0, imem_req}, 32'd1);
        check("p1_first_addr", imem_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("p1_valid_c1", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("p1_valid_c2", {31'b0, out_valid}, 32'd1);
        drain("p1_drain");

        // Consumer stalled: buffer fills to DEPTH and requests stop.
        do_redirect(32'h40);
        tick(10);
        @(negedge clk);
        check("p2_valid", {31'b0, out_valid}, 32'd1);
        check("p2_head_pc", out_pc, 32'h40);
        check("p2_head_instr", out_instr, instr_of(32'h40));
        check("p2_req_low", {31'b0, imem_req}, 32'd0);
        gnt_en = 1'b0;
        expect_pc(32'h40);
        expect_pc(32'h44);
        drain("p2_drain");
        @(negedge clk);
        check("p2_only_two", {31'b0, out_valid}, 32'd0);

        // Redirect while a slow response is outstanding.
        rdy_en = 1'b0;
        lat    = 3;
        gnt_en = 1'b1;
        wait_grant("p3_grant");
        do_redirect(32'h0000_0103);
        lat = 1;
        k   = 0;
        do begin
            @(negedge clk);
            if (!imem_req) k++;
        end while (!imem_req && k < 10);
        check("p3_drop_cycles", k, 32'd2);
        check("p3_new_addr", imem_addr, 32'h100);
        expect_pc(32'h100);
        expect_pc(32'h104);
        rdy_en = 1'b1;
        drain("p3_drain");

        // Redirect coinciding with rvalid and a pop.
        mon_en    = 1'b0;
        rdy_force = 1'b1;
        hit       = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && imem_rvalid) begin
                redirect    = 1'b1;
                redirect_pc = 32'h200;
                hit         = 1'b1;
            end
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL p4_align: got no rvalid+pop cycle expected one");
            redirect    = 1'b1;
            redirect_pc = 32'h200;
        end
        @(posedge clk);
        #1;
        redirect  = 1'b0;
        rdy_force = 1'b0;
        mon_en    = 1'b1;
        expect_pc(32'h200);
        expect_pc(32'h204);
        @(negedge clk);
        check("p4_flushed", {31'b0, out_valid}, 32'd0);
        drain("p4_drain");

        // Address wrap at the top of the space; low bits are dropped.
        do_redirect(32'hFFFF_FFFF);
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        drain("p5_drain");

        // Reset while a request is outstanding; its late response is ignored.
        rdy_en = 1'b0;
        lat    = 3;
        do_redirect(32'h500);
        wait_grant("p6_grant");
        lat = 1;
        rst = 1'b1;
        @(negedge clk);
        check("p6_rst_valid", {31'b0, out_valid}, 32'd0);
        check("p6_rst_req", {31'b0, imem_req}, 32'd0);
        check("p6_rst_pc", out_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_pc(32'h0);
        expect_pc(32'h4);
        rdy_en = 1'b1;
        drain("p6_drain");

`ifdef FETCH_PERF_CNT_EN
        rdy_en = 1'b0;
        gnt_en = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("p7_cnt_reset", stall_cnt, 32'd0);
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        tick(10);
        rdy_force = 1'b0;
        @(negedge clk);
        check("p7_stall_cnt", stall_cnt, 32'd10);
`endif

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
